// File: rtl/uart_tx_stream_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_arb_pkg
// Brief    : Shared types and constants for the UART TX stream arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package uart_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    TAG    = 2'd1,
    STREAM = 2'd2
  } arb_state_e;

  localparam logic [7:0] TAG_PREFIX   = 8'hA0;
  localparam int         MAX_CHANNELS = 16;

  // Grant index width; a single channel still needs a 1-bit index.
  function automatic int gid_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_stream_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_stream_arbiter_if
// Brief    : Producer byte streams plus UART transmitter byte handshake.
// Revision : 1.0 - initial release
// ============================================================================
interface uart_tx_stream_arbiter_if #(
  parameter int NUM_CHANNELS = 4,
  parameter int DATA_WIDTH   = 8
);
  logic [NUM_CHANNELS-1:0]            in_valid;
  logic [NUM_CHANNELS-1:0]            in_last;
  logic [NUM_CHANNELS*DATA_WIDTH-1:0] in_data;
  logic [NUM_CHANNELS-1:0]            in_ready;
  logic                               tx_valid;
  logic [DATA_WIDTH-1:0]              tx_data;
  logic                               tx_ready;

  // Environment side: producers and the transmitter.
  modport master (
    output in_valid, in_last, in_data, tx_ready,
    input  in_ready, tx_valid, tx_data
  );

  // Arbiter side.
  modport slave (
    input  in_valid, in_last, in_data, tx_ready,
    output in_ready, tx_valid, tx_data
  );
endinterface
`default_nettype wire

// File: rtl/uart_tx_stream_arbiter_rr_priority_pick.sv
`default_nettype none
// ============================================================================
// Module   : rr_priority_pick
// Brief    : Combinational round-robin pick: first set request at/above ptr.
// Revision : 1.0 - initial release
// ============================================================================
module rr_priority_pick #(
  parameter int N  = 4,
  parameter int GW = 2
) (
  input  logic [N-1:0]  req_i,
  input  logic [GW-1:0] ptr_i,
  output logic          any_o,
  output logic [GW-1:0] idx_o
);

  always_comb begin
    int j;
    any_o = |req_i;
    idx_o = '0;
    // Walk offsets downward so the smallest offset from ptr is written last.
    for (int i = N - 1; i >= 0; i--) begin
      j = int'(ptr_i) + i;
      if (j >= N) j = j - N;
      if (req_i[j]) idx_o = GW'(j);
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_tx_stream_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_stream_arbiter
// Brief    : Packet-granular round-robin sharing of one UART TX byte port.
//            Define CHANNEL_TAG_EN to prefix each packet with 8'hA0|grant_id.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_stream_arbiter
  import uart_arb_pkg::*;
#(
  parameter  int NUM_CHANNELS = 4,
  parameter  int DATA_WIDTH   = 8,
  localparam int GW           = gid_width(NUM_CHANNELS)
) (
  input  logic                        clock,
  input  logic                        reset,
  uart_tx_stream_arbiter_if.slave     bus,
  output logic                        busy,
  output logic [GW-1:0]               grant_id
);

  arb_state_e                state_q, state_d;
  logic [GW-1:0]             grant_q, grant_d;
  logic [GW-1:0]             rr_ptr_q, rr_ptr_d;

  logic                      w_pick_any;
  logic [GW-1:0]             w_pick_idx;
  logic [NUM_CHANNELS-1:0]   w_in_ready;
  logic                      w_tx_valid;
  logic [DATA_WIDTH-1:0]     w_tx_data;

  rr_priority_pick #(
    .N  (NUM_CHANNELS),
    .GW (GW)
  ) u_pick (
    .req_i (bus.in_valid),
    .ptr_i (rr_ptr_q),
    .any_o (w_pick_any),
    .idx_o (w_pick_idx)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    rr_ptr_d   = rr_ptr_q;
    w_in_ready = '0;
    w_tx_valid = 1'b0;
    w_tx_data  = '0;
    case (state_q)
      IDLE: begin
        if (w_pick_any) begin
          grant_d = w_pick_idx;
`ifdef CHANNEL_TAG_EN
          state_d = TAG;
`else
          state_d = STREAM;
`endif
        end
      end
`ifdef CHANNEL_TAG_EN
      TAG: begin
        w_tx_valid = 1'b1;
        w_tx_data  = DATA_WIDTH'(TAG_PREFIX) | DATA_WIDTH'(grant_q);
        if (bus.tx_ready) state_d = STREAM;
      end
`endif
      STREAM: begin
        w_tx_valid          = bus.in_valid[grant_q];
        w_tx_data           = bus.in_data[grant_q*DATA_WIDTH +: DATA_WIDTH];
        w_in_ready[grant_q] = bus.tx_ready;
        // Packet ends only when the last byte is actually accepted.
        if (bus.in_valid[grant_q] && bus.tx_ready && bus.in_last[grant_q]) begin
          rr_ptr_d = (grant_q == GW'(NUM_CHANNELS - 1)) ? '0 : grant_q + GW'(1);
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.in_ready = w_in_ready;
  assign bus.tx_valid = w_tx_valid;
  assign bus.tx_data  = w_tx_data;
  assign busy         = (state_q != IDLE);
  assign grant_id     = grant_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_stream_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_stream_arbiter
// Brief    : Scoreboard bench for uart_tx_stream_arbiter (CHANNEL_TAG_EN aware).
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_stream_arbiter;
  import uart_arb_pkg::*;

  localparam int N = 4;
  localparam int W = 8;
`ifdef CHANNEL_TAG_EN
  localparam int T = 1;
`else
  localparam int T = 0;
`endif

  typedef struct { logic [1:0] ch; logic [7:0] d; logic last; } beat_t;
  typedef struct { logic [1:0] ch; logic [7:0] d; logic tag;  } exp_t;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       busy;
  logic [1:0] grant_id;

  always #5 clock = ~clock;

  uart_tx_stream_arbiter_if #(.NUM_CHANNELS(N), .DATA_WIDTH(W)) bus ();

  uart_tx_stream_arbiter #(.NUM_CHANNELS(N), .DATA_WIDTH(W)) dut (
    .clock    (clock),
    .reset    (reset),
    .bus      (bus),
    .busy     (busy),
    .grant_id (grant_id)
  );

  beat_t      chq [N][$];
  exp_t       sb [$];
  int         xfer_cyc [$];
  int         cyc = 0;
  int         vectors = 0;
  int         miscompares = 0;
  int         stall_checks = 0;
  logic       toggle_en = 1'b0;
  logic       stalled_q = 1'b0;
  logic [7:0] stall_data = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_pkt(input int ch, input int n, input logic [7:0] b0,
                          input logic [7:0] b1, input logic [7:0] b2, input logic [7:0] b3);
    logic [7:0] b [4];
    b[0] = b0; b[1] = b1; b[2] = b2; b[3] = b3;
    if (T == 1) sb.push_back('{ch: 2'(ch), d: TAG_PREFIX | 8'(ch), tag: 1'b1});
    for (int i = 0; i < n; i++) begin
      chq[ch].push_back('{ch: 2'(ch), d: b[i], last: (i == n - 1)});
      sb.push_back('{ch: 2'(ch), d: b[i], tag: 1'b0});
    end
  endtask

  // One clock: drive inputs on the falling edge, sample 1ns later.
  task automatic cycle();
    exp_t       e;
    logic [3:0] m;
    @(negedge clock);
    cyc++;
    for (int c = 0; c < N; c++) begin
      if (chq[c].size() > 0) begin
        bus.in_valid[c]      = 1'b1;
        bus.in_last[c]       = chq[c][0].last;
        bus.in_data[c*W +: W] = chq[c][0].d;
      end else begin
        bus.in_valid[c]      = 1'b0;
        bus.in_last[c]       = 1'b0;
        bus.in_data[c*W +: W] = '0;
      end
    end
    bus.tx_ready = toggle_en ? cyc[0] : 1'b1;
    #1;
    if (reset) begin
      stalled_q = 1'b0;
    end else begin
      m = 4'b0001 << grant_id;
      check("in_ready_only_granted", 32'(bus.in_ready & ~m), 32'd0);
      if (stalled_q && bus.tx_valid) begin
        stall_checks++;
        check("stall_data_hold", 32'(bus.tx_data), 32'(stall_data));
      end
      if (bus.tx_valid && bus.tx_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_byte_sb_size", 32'(sb.size()), 32'd1);
        end else begin
          e = sb.pop_front();
          check("tx_data", 32'(bus.tx_data), 32'(e.d));
          check("grant_id", 32'(grant_id), 32'(e.ch));
          check("in_ready_on_xfer", 32'(bus.in_ready), e.tag ? 32'd0 : 32'(m));
        end
        xfer_cyc.push_back(cyc);
      end
      stalled_q  = bus.tx_valid && !bus.tx_ready;
      stall_data = bus.tx_data;
      for (int c = 0; c < N; c++)
        if (bus.in_valid[c] && bus.in_ready[c]) void'(chq[c].pop_front());
    end
  endtask

  task automatic drain(input string tag, input int budget);
    int n = 0;
    while (sb.size() > 0 && n < budget) begin
      cycle();
      n++;
    end
    check(tag, 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout vectors=%0d", vectors);
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int n;
    bus.in_valid = 4'hF;
    bus.in_last  = '0;
    bus.in_data  = '0;
    bus.tx_ready = 1'b1;

    // Reset held 5 cycles with every channel requesting.
    repeat (5) begin
      @(negedge clock); #1;
      check("rst_in_ready", 32'(bus.in_ready), 32'd0);
      check("rst_tx_valid", 32'(bus.tx_valid), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
    end
    check("rst_grant_id", 32'(grant_id), 32'd0);
    check("rst_tx_data", 32'(bus.tx_data), 32'd0);
    @(negedge clock);
    bus.in_valid = '0;
    reset = 1'b0;

    // Single packet on ch2: one arbitration cycle, then back-to-back bytes.
    base = cyc;
    xfer_cyc.delete();
    push_pkt(2, 3, 8'h11, 8'h22, 8'h33, 8'h00);
    drain("drain_single_ch2", 20);
    check("single_xfer_count", 32'(xfer_cyc.size()), 32'(3 + T));
    for (int i = 0; i < xfer_cyc.size(); i++)
      check("single_xfer_cycle", 32'(xfer_cyc[i]), 32'(base + 2 + i));

    // rr_ptr is 3 now: ch3 beats ch0.
    push_pkt(3, 1, 8'h3A, 8'h00, 8'h00, 8'h00);
    push_pkt(0, 1, 8'h0A, 8'h00, 8'h00, 8'h00);
    drain("drain_rr3", 30);
    push_pkt(3, 1, 8'h3B, 8'h00, 8'h00, 8'h00);
    drain("drain_ch3_to_ptr0", 20);

    // rr_ptr=0, all four request: order 0,1,2,3 with one bubble between packets.
    xfer_cyc.delete();
    for (int c = 0; c < N; c++) push_pkt(c, 2, 8'(8'h40 + 2*c), 8'(8'h41 + 2*c), 8'h00, 8'h00);
    drain("drain_all_ptr0", 60);
    check("inter_packet_bubble", 32'(xfer_cyc[2+T] - xfer_cyc[1+T]), 32'd2);

    // Move rr_ptr to 2, then all four: order 2,3,0,1.
    push_pkt(1, 1, 8'h1C, 8'h00, 8'h00, 8'h00);
    drain("drain_ch1_to_ptr2", 20);
    for (int k = 0; k < N; k++) begin
      int c = (k + 2) % N;
      push_pkt(c, 2, 8'(8'h80 + 2*c), 8'(8'h81 + 2*c), 8'h00, 8'h00);
    end
    drain("drain_all_ptr2", 60);

    // Backpressure on ch1: tx_ready toggling.
    toggle_en = 1'b1;
    stall_checks = 0;
    push_pkt(1, 4, 8'h06, 8'h07, 8'h08, 8'h09);
    drain("drain_backpressure", 60);
    toggle_en = 1'b0;
    check("stall_observed", 32'(stall_checks > 0), 32'd1);

    // Reset after the 2nd byte of a ch0 packet (rr_ptr=2 before reset).
    xfer_cyc.delete();
    push_pkt(0, 3, 8'h01, 8'h01, 8'h01, 8'h00);
    n = 0;
    while (xfer_cyc.size() < 2 + T && n < 20) begin
      cycle();
      n++;
    end
    check("midpkt_two_bytes_seen", 32'(xfer_cyc.size()), 32'(2 + T));
    @(posedge clock);
    #2;
    reset = 1'b1;
    #1;
    check("midpkt_rst_busy", 32'(busy), 32'd0);
    check("midpkt_rst_tx_valid", 32'(bus.tx_valid), 32'd0);
    chq[0].delete();
    sb.delete();
    cycle();
    cycle();
    reset = 1'b0;
    // ch1 before ch2 only if rr_ptr was cleared to 0.
    push_pkt(1, 1, 8'h51, 8'h00, 8'h00, 8'h00);
    push_pkt(2, 1, 8'h52, 8'h00, 8'h00, 8'h00);
    drain("drain_post_reset_rr0", 30);
    push_pkt(3, 1, 8'h77, 8'h00, 8'h00, 8'h00);
    drain("drain_post_reset_ch3", 20);
    repeat (3) cycle();
    check("final_busy", 32'(busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
